// File: rtl/data_path.sv
// Histogram-equalization engine: clears two histograms, histograms the image, builds a
// CDF lookup table, remaps the image in place and histograms the result, then halts.

module image_ram #(
  parameter int IMG_WORDS = 8192,
  parameter int AW        = 13,
  parameter     INIT_FILE = "image.mif"
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic          we,
  input  logic [127:0]  d,
  output logic [127:0]  q
);
  logic [127:0] mem [0:IMG_WORDS-1];

  // Single port, registered read; read-during-write returns the old word.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= d;
    q <= mem[addr];
  end
endmodule

module hist_ram (
  input  logic        clk,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata
);
  logic [15:0] RAM [0:255];

  always_ff @(posedge clk) begin
    if (we) RAM[addr] <= wdata;
  end

  assign rdata = RAM[addr];
endmodule

module data_path #(
  parameter int IMG_WORDS = 8192,
  parameter     INIT_FILE = "image.mif"
) (
  input  logic        clk,
  input  logic        reset,
  output logic [17:0] pc,
  output logic        finish
);
  localparam int AW    = $clog2(IMG_WORDS);
  localparam int N_PIX = IMG_WORDS * 16;
  localparam int SH    = $clog2(N_PIX);
  localparam logic [AW-1:0] LAST_WORD = AW'(IMG_WORDS - 1);

  typedef enum logic [2:0] {
    S_CLEAR, S_HFETCH, S_HPIX, S_CDF, S_RFETCH, S_RPIX, S_RWRITE, S_DONE
  } state_t;

  state_t        state, state_n;
  logic [7:0]    cnt, cnt_n;
  logic [AW-1:0] word, word_n;
  logic [3:0]    k, k_n;
  logic [17:0]   acc, acc_n;
  logic [17:0]   pc_d;
  logic          finish_d;

  logic [127:0]  img_q;
  logic [127:0]  hold;
  logic          img_we;
  logic [7:0]    lut [0:255];
  logic [7:0]    pix, lut_pix, lut_val;
  logic [17:0]   cdf_sum;

  logic          h1_we, h2_we;
  logic [7:0]    h1_addr, h2_addr;
  logic [15:0]   h1_wdata, h2_wdata, h1_rd, h2_rd;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  image_ram #(.IMG_WORDS(IMG_WORDS), .AW(AW), .INIT_FILE(INIT_FILE)) n_image (
    .clk  (clk),
    .addr (word),
    .we   (img_we),
    .d    (hold),
    .q    (img_q)
  );

  hist_ram data_m (
    .clk   (clk),
    .we    (h1_we),
    .addr  (h1_addr),
    .wdata (h1_wdata),
    .rdata (h1_rd)
  );

  hist_ram data_m2 (
    .clk   (clk),
    .we    (h2_we),
    .addr  (h2_addr),
    .wdata (h2_wdata),
    .rdata (h2_rd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_CLEAR;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    word_n  = word;
    k_n     = k;
    case (state)
      S_CLEAR: begin
        cnt_n = cnt + 8'd1;
        if (cnt == 8'hFF) begin
          state_n = S_HFETCH;
          word_n  = '0;
          k_n     = '0;
        end
      end
      S_HFETCH: state_n = S_HPIX;
      S_HPIX: begin
        k_n = k + 4'd1;
        if (k == 4'hF) begin
          if (word == LAST_WORD) begin
            state_n = S_CDF;
            word_n  = '0;
          end else begin
            state_n = S_HFETCH;
            word_n  = word + AW'(1);
          end
        end
      end
      S_CDF: begin
        cnt_n = cnt + 8'd1;
        if (cnt == 8'hFF) state_n = S_RFETCH;
      end
      S_RFETCH: state_n = S_RPIX;
      S_RPIX: begin
        // k parks at 15 through the write cycle so pc never steps backwards.
        if (k == 4'hF) state_n = S_RWRITE;
        else           k_n     = k + 4'd1;
      end
      S_RWRITE: begin
        k_n = '0;
        if (word == LAST_WORD) begin
          state_n = S_DONE;
        end else begin
          state_n = S_RFETCH;
          word_n  = word + AW'(1);
        end
      end
      S_DONE:  state_n = S_DONE;
      default: state_n = S_CLEAR;
    endcase
  end

  // pc/finish are registered, so they are encoded from the state being entered.
  always_comb begin
    pc_d     = '0;
    finish_d = 1'b0;
    case (state_n)
      S_HFETCH, S_HPIX:           pc_d = {1'b0, 17'({word_n, k_n})};
      S_RFETCH, S_RPIX, S_RWRITE: pc_d = {1'b1, 17'({word_n, k_n})};
      S_DONE: begin
        pc_d     = '1;
        finish_d = 1'b1;
      end
      default: pc_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      word   <= '0;
      k      <= '0;
      acc    <= '0;
      pc     <= '0;
      finish <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      word   <= word_n;
      k      <= k_n;
      acc    <= acc_n;
      pc     <= pc_d;
      finish <= finish_d;
    end
  end

  assign pix     = img_q[{k, 3'b000} +: 8];
  assign lut_pix = lut[pix];
  assign cdf_sum = acc + 18'(h1_rd);
  assign lut_val = 8'((26'(cdf_sum) * 26'd255) >> SH);

  always_comb begin
    acc_n = acc;
    if (state == S_CLEAR)    acc_n = '0;
    else if (state == S_CDF) acc_n = cdf_sum;
  end

  always_ff @(posedge clk) begin
    if (state == S_CDF)  lut[cnt] <= lut_val;
    if (state == S_RPIX) hold[{k, 3'b000} +: 8] <= lut_pix;
  end

  assign img_we   = (state == S_RWRITE);
  assign h1_we    = (state == S_CLEAR) || (state == S_HPIX);
  assign h1_addr  = (state == S_HPIX) ? pix : cnt;
  assign h1_wdata = (state == S_CLEAR) ? 16'd0 : sat_inc(h1_rd);
  assign h2_we    = (state == S_CLEAR) || (state == S_RPIX);
  assign h2_addr  = (state == S_RPIX) ? lut_pix : cnt;
  assign h2_wdata = (state == S_CLEAR) ? 16'd0 : sat_inc(h2_rd);
endmodule

// File: tb/tb_data_path.sv
// Bench for data_path: two instances (4 and 16 image words), directed table vectors,
// ramp/random images against a plain-arithmetic equalization model, and reset corner cases.

module tb_data_path;
  logic        clk = 1'b0;
  logic        reset4, reset16;
  logic [17:0] pc4, pc16;
  logic        fin4, fin16;

  always #5 clk = ~clk;

  data_path #(.IMG_WORDS(4), .INIT_FILE("image.mif")) dut4 (
    .clk(clk), .reset(reset4), .pc(pc4), .finish(fin4)
  );
  data_path #(.IMG_WORDS(16), .INIT_FILE("image.mif")) dut16 (
    .clk(clk), .reset(reset16), .pc(pc16), .finish(fin16)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    int         hist_a;
    int         hist_b;
    logic [7:0] out_a;
    logic [7:0] out_b;
  } vec_t;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [127:0] img     [16];
  logic [127:0] exp_img [16];
  int           h1m     [256];
  int           h2m     [256];
  logic [7:0]   lutm    [256];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: histogram, inclusive CDF scaled to 0..255, remap, histogram again.
  task automatic model(input int nw);
    int n, sh, cdf;
    logic [7:0] px;
    n   = nw * 16;
    sh  = $clog2(n);
    cdf = 0;
    for (int v = 0; v < 256; v++) begin
      h1m[v] = 0;
      h2m[v] = 0;
    end
    for (int w = 0; w < nw; w++)
      for (int p = 0; p < 16; p++) begin
        px = img[w][8*p +: 8];
        if (h1m[px] < 65535) h1m[px]++;
      end
    for (int v = 0; v < 256; v++) begin
      cdf += h1m[v];
      lutm[v] = 8'((cdf * 255) >> sh);
    end
    for (int w = 0; w < nw; w++)
      for (int p = 0; p < 16; p++) begin
        px = lutm[img[w][8*p +: 8]];
        exp_img[w][8*p +: 8] = px;
        if (h2m[px] < 65535) h2m[px]++;
      end
  endtask

  function automatic logic [127:0] dut_word(input bit big, input int i);
    return big ? dut16.n_image.mem[i] : dut4.n_image.mem[i];
  endfunction
  function automatic logic [15:0] dut_h1(input bit big, input int v);
    return big ? dut16.data_m.RAM[v] : dut4.data_m.RAM[v];
  endfunction
  function automatic logic [15:0] dut_h2(input bit big, input int v);
    return big ? dut16.data_m2.RAM[v] : dut4.data_m2.RAM[v];
  endfunction
  function automatic logic [17:0] dut_pc(input bit big);
    return big ? pc16 : pc4;
  endfunction
  function automatic logic dut_fin(input bit big);
    return big ? fin16 : fin4;
  endfunction

  task automatic set_reset(input bit big, input logic v);
    if (big) reset16 = v;
    else     reset4  = v;
  endtask

  task automatic load(input bit big, input int nw);
    for (int i = 0; i < nw; i++) begin
      if (big) dut16.n_image.mem[i] = img[i];
      else     dut4.n_image.mem[i]  = img[i];
    end
  endtask

  task automatic start(input bit big, input int nw, input bit do_load);
    @(negedge clk);
    set_reset(big, 1'b0);
    if (do_load) load(big, nw);
    repeat (3) @(negedge clk);
    set_reset(big, 1'b1);
  endtask

  task automatic wait_finish(input bit big, input string tag);
    int i;
    i = 0;
    while (dut_fin(big) !== 1'b1 && i < 20000) begin
      @(negedge clk);
      i++;
    end
    check({tag, " finish"}, 128'(dut_fin(big)), 128'd1);
  endtask

  task automatic verify(input bit big, input int nw, input string tag);
    check({tag, " finish"}, 128'(dut_fin(big)), 128'd1);
    check({tag, " pc"}, 128'(dut_pc(big)), 128'h3FFFF);
    for (int v = 0; v < 256; v++) begin
      check($sformatf("%s data_m[%0d]", tag, v), 128'(dut_h1(big, v)), 128'(h1m[v]));
      check($sformatf("%s data_m2[%0d]", tag, v), 128'(dut_h2(big, v)), 128'(h2m[v]));
    end
    for (int w = 0; w < nw; w++)
      check($sformatf("%s word[%0d]", tag, w), dut_word(big, w), exp_img[w]);
  endtask

  initial begin
    vec_t        vecs [5];
    logic [17:0] target;
    int          i;
    int          maxv;

    vecs[0] = '{8'h00, 8'h00, 64, 64, 8'hFF, 8'hFF};
    vecs[1] = '{8'h10, 8'h80, 32, 32, 8'h7F, 8'hFF};
    vecs[2] = '{8'hAB, 8'hAB, 64, 64, 8'hFF, 8'hFF};
    vecs[3] = '{8'h00, 8'hFF, 32, 32, 8'h7F, 8'hFF};
    vecs[4] = '{8'hFE, 8'h01, 32, 32, 8'hFF, 8'h7F};

    // Power-on: both instances held in reset with an all-zero image in the small one.
    reset4  = 1'b0;
    reset16 = 1'b0;
    for (int w = 0; w < 16; w++) img[w] = '0;
    load(1'b0, 4);
    model(4);
    repeat (5) @(negedge clk);
    check("reset pc4", 128'(pc4), 128'd0);
    check("reset finish4", 128'(fin4), 128'd0);
    check("reset pc16", 128'(pc16), 128'd0);
    check("reset finish16", 128'(fin16), 128'd0);

    // Released at a negedge: edge N=256 ends CLEAR, N=257 is the fetch, pixel n at N=257+n.
    reset4 = 1'b1;
    repeat (256) @(posedge clk); #1;
    check("pc end of clear", 128'(pc4), 128'd0);
    repeat (4) @(posedge clk); #1;
    check("pc pixel 3", 128'(pc4), 128'd3);
    repeat (10) @(posedge clk); #1;
    check("pc pixel 13", 128'(pc4), 128'd13);
    repeat (3) @(posedge clk); #1;
    check("pc fetch word1", 128'(pc4), 128'd16);
    repeat (2) @(posedge clk); #1;
    check("pc pixel 17", 128'(pc4), 128'd17);
    check("finish low while running", 128'(fin4), 128'd0);
    wait_finish(1'b0, "zero");
    verify(1'b0, 4, "zero");

    // Table vectors: words 0-1 filled with a, words 2-3 with b.
    for (int r = 0; r < 5; r++) begin
      for (int w = 0; w < 4; w++) img[w] = (w < 2) ? {16{vecs[r].a}} : {16{vecs[r].b}};
      start(1'b0, 4, 1'b1);
      wait_finish(1'b0, $sformatf("vec%0d", r));
      check($sformatf("vec%0d hist a", r), 128'(dut_h1(1'b0, vecs[r].a)), 128'(vecs[r].hist_a));
      check($sformatf("vec%0d hist b", r), 128'(dut_h1(1'b0, vecs[r].b)), 128'(vecs[r].hist_b));
      check($sformatf("vec%0d hist empty", r), 128'(dut_h1(1'b0, 8'(vecs[r].a + 8'd1))), 128'd0);
      check($sformatf("vec%0d hist2 a", r), 128'(dut_h2(1'b0, vecs[r].out_a)), 128'(vecs[r].hist_a));
      check($sformatf("vec%0d hist2 b", r), 128'(dut_h2(1'b0, vecs[r].out_b)), 128'(vecs[r].hist_b));
      for (int w = 0; w < 4; w++)
        check($sformatf("vec%0d word[%0d]", r, w), dut_word(1'b0, w),
              (w < 2) ? {16{vecs[r].out_a}} : {16{vecs[r].out_b}});
      check($sformatf("vec%0d pc", r), 128'(pc4), 128'h3FFFF);
    end

    // Ramp on the 16-word instance: identity LUT, flat histograms.
    for (int w = 0; w < 16; w++)
      for (int p = 0; p < 16; p++) img[w][8*p +: 8] = 8'(w * 16 + p);
    start(1'b1, 16, 1'b1);
    wait_finish(1'b1, "ramp");
    for (int v = 0; v < 256; v++) begin
      check($sformatf("ramp data_m[%0d]", v), 128'(dut_h1(1'b1, v)), 128'd1);
      check($sformatf("ramp data_m2[%0d]", v), 128'(dut_h2(1'b1, v)), 128'd1);
    end
    for (int w = 0; w < 16; w++)
      check($sformatf("ramp word[%0d]", w), dut_word(1'b1, w), img[w]);

    // Random images with varying value spread, checked against the model.
    for (int r = 0; r < 4; r++) begin
      maxv = (r == 0) ? 255 : (r == 1) ? 15 : (r == 2) ? 3 : 200;
      for (int w = 0; w < 16; w++)
        for (int p = 0; p < 16; p++) img[w][8*p +: 8] = 8'($urandom_range(0, maxv));
      model((r % 2 == 0) ? 16 : 4);
      start((r % 2 == 0), (r % 2 == 0) ? 16 : 4, 1'b1);
      wait_finish((r % 2 == 0), $sformatf("rand%0d", r));
      verify((r % 2 == 0), (r % 2 == 0) ? 16 : 4, $sformatf("rand%0d", r));
    end

    // Reset during REMAP at word 2 pixel 8: words 0-1 are already rewritten.
    for (int w = 0; w < 4; w++)
      for (int p = 0; p < 16; p++) img[w][8*p +: 8] = 8'($urandom_range(0, 255));
    model(4);
    start(1'b0, 4, 1'b1);
    target = {1'b1, 17'd40};
    i = 0;
    while (pc4 !== target && i < 5000) begin
      @(negedge clk);
      i++;
    end
    check("midremap reached", 128'(pc4), 128'(target));
    reset4 = 1'b0;
    #1;
    check("midremap async pc", 128'(pc4), 128'd0);
    check("midremap async finish", 128'(fin4), 128'd0);
    for (int w = 0; w < 2; w++) img[w] = exp_img[w];
    model(4);
    repeat (2) @(negedge clk);
    reset4 = 1'b1;
    wait_finish(1'b0, "restart");
    verify(1'b0, 4, "restart");

    // Hold in DONE: nothing may move.
    repeat (1000) @(negedge clk);
    verify(1'b0, 4, "hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
